// File: rtl/rom_rr_arbiter_pkg.sv
// Shared constants and helpers for the ROM round-robin arbiter slice.
// Default sizes match the 4x4 ROM instance this arbiter fronts.
package rom_rr_arbiter_pkg;

   localparam int ROM_ADDR_WIDTH = 2;
   localparam int ROM_DATA_WIDTH = 4;
   localparam int ROM_NUM_REQ    = 4;

   // Pointer width for n requesters; never less than one bit.
   function automatic int clog2_req(input int n);
      int w;
      w = 1;
      for (int i = 0; i < 31; i++) begin
         if ((1 << w) < n) begin
            w = w + 1;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/rom_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: rotate requests so prio_ptr is bit 0,
// isolate the lowest set bit, then rotate the one-hot result back.
module rr_pick
   import rom_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ = ROM_NUM_REQ,
   parameter int PTR_W   = clog2_req(ROM_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [PTR_W-1:0]   prio_ptr,
   output logic [NUM_REQ-1:0] gnt
);

   logic [NUM_REQ-1:0] rot_req;
   logic [NUM_REQ-1:0] rot_gnt;

   always_comb begin
      rot_req = '0;
      gnt     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         rot_req[k] = req[(int'(prio_ptr) + k) % NUM_REQ];
      end
      rot_gnt = rot_req & (~rot_req + NUM_REQ'(1));
      for (int k = 0; k < NUM_REQ; k++) begin
         gnt[(int'(prio_ptr) + k) % NUM_REQ] = rot_gnt[k];
      end
   end

endmodule

// File: rtl/rom_rr_arbiter.sv
// Round-robin arbiter sharing one registered-read ROM port between requesters;
// read data returns to the winner exactly one cycle after its grant.
module rom_rr_arbiter
   import rom_rr_arbiter_pkg::*;
#(
   parameter int NUM_REQ    = ROM_NUM_REQ,
   parameter int ADDR_WIDTH = ROM_ADDR_WIDTH,
   parameter int DATA_WIDTH = ROM_DATA_WIDTH
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          arb_en,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [NUM_REQ-1:0]            rsp_valid,
   output logic [DATA_WIDTH-1:0]         rsp_data,
   output logic                          rom_en,
   output logic [ADDR_WIDTH-1:0]         rom_addr,
   input  logic [DATA_WIDTH-1:0]         rom_data
);

   localparam int PTR_W = clog2_req(NUM_REQ);

   logic [PTR_W-1:0]   prio_ptr;
   logic [PTR_W-1:0]   next_ptr;
   logic [NUM_REQ-1:0] rsp_id_q;
   logic [NUM_REQ-1:0] pick_gnt;

   rr_pick #(
      .NUM_REQ (NUM_REQ),
      .PTR_W   (PTR_W)
   ) u_pick (
      .req      (req),
      .prio_ptr (prio_ptr),
      .gnt      (pick_gnt)
   );

   assign gnt    = (arb_en && !rst) ? pick_gnt : '0;
   assign rom_en = |gnt;

   always_comb begin
      next_ptr = prio_ptr;
      rom_addr = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (gnt[i]) begin
            next_ptr = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
            rom_addr = addr[i*ADDR_WIDTH +: ADDR_WIDTH];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prio_ptr <= '0;
         rsp_id_q <= '0;
      end else begin
         prio_ptr <= next_ptr;
         rsp_id_q <= gnt;
      end
   end

   // Reset drops the in-flight response immediately, not one cycle later.
   assign rsp_valid = rst ? '0 : rsp_id_q;
   assign rsp_data  = (!rst && |rsp_id_q) ? rom_data : '0;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// Self-checking bench for rom_rr_arbiter with a 4x4 ROM preloaded A,8,F,2.
module tb_rom_rr_arbiter;
   import rom_rr_arbiter_pkg::*;

   localparam int N  = ROM_NUM_REQ;
   localparam int AW = ROM_ADDR_WIDTH;
   localparam int DW = ROM_DATA_WIDTH;

   logic            clk;
   logic            rst;
   logic            arb_en;
   logic [N-1:0]    req;
   logic [N*AW-1:0] addr;
   logic [N-1:0]    gnt;
   logic [N-1:0]    rsp_valid;
   logic [DW-1:0]   rsp_data;
   logic            rom_en;
   logic [AW-1:0]   rom_addr;
   logic [DW-1:0]   rom_data;

   logic [DW-1:0]   rom_mem [4];

   int total;
   int bad;

   typedef struct {
      logic         rst;
      logic         en;
      logic [N-1:0] req;
      logic [7:0]   addr;
      logic [N-1:0] gnt;
   } vec_t;

   typedef struct {
      logic [N-1:0]  valid;
      logic [DW-1:0] data;
   } rsp_t;

   vec_t vecs [27];
   rsp_t sb_q [$];

   rom_rr_arbiter #(
      .NUM_REQ    (N),
      .ADDR_WIDTH (AW),
      .DATA_WIDTH (DW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .arb_en    (arb_en),
      .req       (req),
      .addr      (addr),
      .gnt       (gnt),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rom_en    (rom_en),
      .rom_addr  (rom_addr),
      .rom_data  (rom_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural stand-in for the existing ROM: registered, enable-gated read.
   always @(posedge clk) begin
      if (rst) begin
         rom_data <= '0;
      end else if (rom_en) begin
         rom_data <= rom_mem[rom_addr];
      end
   end

   function automatic logic [AW-1:0] slice_of(input logic [N-1:0] g, input logic [7:0] a);
      logic [AW-1:0] s;
      s = '0;
      for (int i = 0; i < N; i++) begin
         if (g[i]) s = a[i*AW +: AW];
      end
      return s;
   endfunction

   task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %0h, want %0h", name, act, exp);
      end
   endtask

   task automatic apply_stimulus(input logic r, input logic e, input logic [N-1:0] q, input logic [7:0] a);
      @(posedge clk);
      #1;
      rst    = r;
      arb_en = e;
      req    = q;
      addr   = a;
      @(negedge clk);
   endtask

   initial begin
      rsp_t exp_rsp;
      rsp_t nxt;
      int   wait0;
      logic [N-1:0] g;

      total = 0;
      bad   = 0;
      rom_mem[0] = 4'hA;
      rom_mem[1] = 4'h8;
      rom_mem[2] = 4'hF;
      rom_mem[3] = 4'h2;
      rst    = 1'b1;
      arb_en = 1'b0;
      req    = '0;
      addr   = '0;

      vecs[0]  = '{1'b1, 1'b1, 4'hF, 8'hE4, 4'h0};
      vecs[1]  = '{1'b1, 1'b1, 4'h0, 8'hE4, 4'h0};
      vecs[2]  = '{1'b0, 1'b1, 4'h0, 8'hE4, 4'h0};
      vecs[3]  = '{1'b0, 1'b1, 4'h0, 8'hE4, 4'h0};
      vecs[4]  = '{1'b0, 1'b1, 4'h0, 8'hE4, 4'h0};
      vecs[5]  = '{1'b0, 1'b1, 4'h0, 8'hE4, 4'h0};
      vecs[6]  = '{1'b0, 1'b1, 4'h0, 8'hE4, 4'h0};
      vecs[7]  = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h1};
      vecs[8]  = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h2};
      vecs[9]  = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h4};
      vecs[10] = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h8};
      vecs[11] = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h1};
      vecs[12] = '{1'b0, 1'b1, 4'h1, 8'hE6, 4'h1};
      vecs[13] = '{1'b0, 1'b1, 4'h0, 8'hE4, 4'h0};
      vecs[14] = '{1'b0, 1'b1, 4'h2, 8'hE4, 4'h2};
      vecs[15] = '{1'b0, 1'b1, 4'hA, 8'hE4, 4'h8};
      vecs[16] = '{1'b0, 1'b1, 4'h2, 8'hE4, 4'h2};
      vecs[17] = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h4};
      vecs[18] = '{1'b0, 1'b0, 4'hF, 8'hE4, 4'h0};
      vecs[19] = '{1'b0, 1'b0, 4'hF, 8'hE4, 4'h0};
      vecs[20] = '{1'b0, 1'b0, 4'hF, 8'hE4, 4'h0};
      vecs[21] = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h8};
      vecs[22] = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h1};
      vecs[23] = '{1'b1, 1'b1, 4'hF, 8'hE4, 4'h0};
      vecs[24] = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h1};
      vecs[25] = '{1'b0, 1'b1, 4'hF, 8'hE4, 4'h2};
      vecs[26] = '{1'b0, 1'b1, 4'h0, 8'hE4, 4'h0};

      sb_q.push_back('{'0, '0});

      for (int v = 0; v < 27; v++) begin
         apply_stimulus(vecs[v].rst, vecs[v].en, vecs[v].req, vecs[v].addr);
         check_output($sformatf("gnt[%0d]", v), 32'(gnt), 32'(vecs[v].gnt));
         check_output($sformatf("rom_en[%0d]", v), 32'(rom_en), 32'(|vecs[v].gnt));
         check_output($sformatf("rom_addr[%0d]", v), 32'(rom_addr),
                      32'(slice_of(vecs[v].gnt, vecs[v].addr)));
         if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("[TB] FAIL scoreboard[%0d]: queue empty", v);
            exp_rsp = '{'0, '0};
         end else begin
            exp_rsp = sb_q.pop_front();
         end
         if (vecs[v].rst) exp_rsp = '{'0, '0};
         check_output($sformatf("rsp_valid[%0d]", v), 32'(rsp_valid), 32'(exp_rsp.valid));
         check_output($sformatf("rsp_data[%0d]", v), 32'(rsp_data), 32'(exp_rsp.data));
         nxt.valid = vecs[v].gnt;
         nxt.data  = (vecs[v].gnt != '0) ? rom_mem[slice_of(vecs[v].gnt, vecs[v].addr)] : '0;
         sb_q.push_back(nxt);
      end

      // Random contention with requester 0 always pending: legal grants and bounded wait.
      wait0 = 0;
      for (int c = 0; c < 24; c++) begin
         apply_stimulus(1'b0, 1'b1, N'($urandom_range(0, 15)) | N'(1), 8'hE4);
         g = gnt;
         check_output($sformatf("gnt_legal[%0d]", c),
                      32'(((g & (g - N'(1))) == '0) && (g != '0) && ((g & ~req) == '0)), 32'd1);
         if (g[0]) wait0 = 0;
         else wait0++;
         check_output($sformatf("starve[%0d]", c), 32'(wait0 < N), 32'd1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/rom_rr_arbiter.md
Name: rom_rr_arbiter

Overview:
- Shares one synchronous-read ROM port (1-cycle registered read, enable-gated) between NUM_REQ requesters.
- Uses round-robin arbitration with one grant per cycle and fully pipelined issue.
- Returns read data to the granted requester exactly one cycle after grant.
- Sits between the requesting engines and the ROM instance; it drives the ROM's en/address and consumes its data output.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_WIDTH, 2, ROM address width.
- DATA_WIDTH, 4, ROM data width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset. Also routed to the ROM's reset.
- arb_en  in  1  arbitration enable. 0 = no grants issued; in-flight response still completes.
- req  in  NUM_REQ  per-requester read request, level. Held high until granted.
- addr  in  NUM_REQ*ADDR_WIDTH  per-requester address; slice i = addr[i*ADDR_WIDTH +: ADDR_WIDTH].
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as req.
- rsp_valid  out  NUM_REQ  one-hot response strobe, registered, 1 cycle after gnt.
- rsp_data  out  DATA_WIDTH  response data, shared by all requesters; 0 when no rsp_valid bit is set.
- rom_en  out  1  ROM read enable = |gnt.
- rom_addr  out  ADDR_WIDTH  address slice of the granted requester; 0 when no grant.
- rom_data  in  DATA_WIDTH  ROM registered output.

Behaviour:
- State:
  - prio_ptr (log2 NUM_REQ bits): index of the highest-priority requester.
  - rsp_id_q (NUM_REQ bits): registered copy of gnt.
- Reset (rst=1 at an edge): prio_ptr<=0, rsp_id_q<=0.
  - Hence rsp_valid=0 and rsp_data=0 in the following cycle.
  - gnt is combinational and is forced to 0 while rst=1.
- Grant:
  - When arb_en=1, rst=0 and req!=0, gnt selects the first set req bit, scanning prio_ptr, prio_ptr+1, ... mod NUM_REQ.
  - Otherwise gnt=0.
- Pointer update at the edge:
  - If gnt[i]=1, prio_ptr<=(i+1) mod NUM_REQ.
  - Else prio_ptr holds.
  - Wrap from NUM_REQ-1 to 0 is required.
- Issue: in cycle N, rom_en=1 and rom_addr=addr slice of the winner. The address is captured by the ROM at the end of cycle N.
  - A requester may change addr while waiting. Only the value present in its grant cycle is used.
- Response: at the edge ending cycle N, rsp_id_q<=gnt.
  - In cycle N+1: rsp_valid=rsp_id_q, and rsp_data=rom_data if |rsp_id_q, else 0.
  - Latency is exactly 1 cycle, with no back-pressure. Requesters must accept rsp_valid unconditionally.
- Throughput: one grant per cycle. Back-to-back grants overlap with responses, so a new grant in N+1 coexists with the response for the N grant.
- Requester protocol:
  - A granted requester deasserts req the cycle after gnt, or keeps it high to request again.
  - Re-requests still obey rotation, so with other requesters pending it waits up to NUM_REQ-1 cycles.
- Starvation bound: a continuously requesting requester is granted within NUM_REQ cycles while arb_en=1.
- Single requester: granted every cycle it requests, regardless of prio_ptr.
- arb_en deasserted: gnt=0, prio_ptr frozen, a pending rsp_id_q still produces its response.
- Reset mid-operation: an in-flight response is dropped (rsp_valid stays 0) and prio_ptr returns to 0.
- The ROM's own output resets to 0 on the same rst.

Decomposition:
- Shared package holds:
  - ROM_ADDR_WIDTH=2, ROM_DATA_WIDTH=4, ROM_NUM_REQ=4 constants.
  - a function for clog2 of NUM_REQ, used for the prio_ptr width.
- One natural sub-module: rr_pick.
  - Purely combinational rotate-priority-rotate-back one-hot picker.
  - Inputs: req, prio_ptr. Output: gnt.
  - Reusable by later arbiters.
- Pointer register, response register and data gating stay in rom_rr_arbiter.
- The bench instantiates the existing 4x4 ROM, preloaded with A,8,F,2 at addresses 0..3.

Test Plan:
- Reset release, req=0 -> gnt=0, rom_en=0, rsp_valid=0, rsp_data=0 for 5 cycles.
- req=4'b0001, addr0=2 held for 1 cycle -> gnt=0001 in cycle N; cycle N+1 rsp_valid=0001, rsp_data=4'hF; prio_ptr=1.
- All four req high continuously; addresses 0,1,2,3 -> grants 0001,0010,0100,1000,0001 on consecutive cycles; rsp_data A,8,F,2 one cycle later, matching rsp_valid.
- req[3] and req[1] high with prio_ptr=2 -> req 3 granted first (data 4'h2 if addr3=3), then req 1; ptr wraps to 0 after req 3, then 2.
- arb_en=0 for 3 cycles while all req high -> no gnt, ptr unchanged; a response issued just before the deassert still appears once.
- rst asserted in the cycle after a grant -> that rsp_valid is suppressed; after release, with all req high, the first grant is 0001.
